// File: rtl/mostrar_resultado.sv
// +-----------------------------------------------------------------------------+
// | mostrar_resultado                                                           |
// | Signed 16-bit product -> sequential double-dabble BCD -> 8-digit 7-seg scan |
// | Optional macro: LEADING_ZERO_BLANK_EN (blank leading zeros, floating minus) |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mostrar_resultado #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [15:0] producto,
  input  logic        valido,
  output logic        ocupado,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_UPDATE  = 2'd2;

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] C_MINUS = 7'b0111111;
  localparam logic [6:0] C_BLANK = 7'b1111111;
  localparam logic [6:0] C_ZERO  = 7'b1000000;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [16:0]     r_mag;
  logic [19:0]     r_bcd;
  logic [19:0]     w_bcd_adj;
  logic [4:0]      r_cnt;
  logic            r_neg;
  logic [16:0]     w_sext;
  logic [16:0]     w_abs;
  logic [7:0][6:0] r_disp;
  logic [7:0][6:0] w_disp;
  logic [CW-1:0]   r_refresh;
  logic [2:0]      r_idx;
  logic [2:0]      w_idx_next;
  logic            w_wrap;
  logic [7:0]      r_an;
  logic [6:0]      r_seg;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (valido) w_next = S_CONVERT;
      S_CONVERT: if (r_cnt == 5'd16) w_next = S_UPDATE;
      S_UPDATE:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ocupado = (r_state != S_IDLE);
  end

  // 17-bit magnitude so that -32768 is representable as +32768
  assign w_sext = {producto[15], producto};
  assign w_abs  = producto[15] ? (~w_sext + 17'd1) : w_sext;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_mag <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (valido) begin
          r_neg <= producto[15];
          r_mag <= w_abs;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        S_CONVERT: begin
          {r_bcd, r_mag} <= {w_bcd_adj[18:0], r_mag, 1'b0};
          r_cnt          <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] w_msd;

  always_comb begin
    w_msd = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_msd = 3'(i);
    end
    w_disp = {8{C_BLANK}};
    for (int i = 0; i < 5; i++) begin
      if (3'(i) <= w_msd) w_disp[i] = f_seg(r_bcd[4*i +: 4]);
    end
    if (r_neg) w_disp[w_msd + 3'd1] = C_MINUS;
  end
`else
  always_comb begin
    w_disp = {8{C_BLANK}};
    for (int i = 0; i < 5; i++) begin
      w_disp[i] = f_seg(r_bcd[4*i +: 4]);
    end
    if (r_neg) w_disp[5] = C_MINUS;
  end
`endif

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_disp    <= {{7{C_BLANK}}, C_ZERO};
    end else if (r_state == S_UPDATE) begin
      r_disp    <= w_disp;
    end
  end

  assign w_wrap     = (r_refresh == CW'(REFRESH_DIV - 1));
  assign w_idx_next = r_idx + 3'd1;

  // AN and SEG advance together so a slot never shows a neighbour's segments
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_refresh <= '0;
      r_idx     <= 3'd0;
      r_an      <= 8'b11111110;
      r_seg     <= C_ZERO;
    end else begin
      r_refresh <= w_wrap ? '0 : r_refresh + CW'(1);
      if (w_wrap) begin
        r_idx <= w_idx_next;
        r_an  <= ~(8'd1 << w_idx_next);
        r_seg <= r_disp[w_idx_next];
      end
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;
  assign DP  = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_mostrar_resultado.sv
// +-----------------------------------------------------------------------------+
// | tb_mostrar_resultado                                                        |
// | Randomised and directed checks of mostrar_resultado against a decimal model |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mostrar_resultado;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] producto = '0;
  logic        valido = 1'b0;
  logic        ocupado;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  int n_vec = 0;
  int n_err = 0;

  mostrar_resultado #(.REFRESH_DIV(RD)) u_dut (
    .CLK100MHZ (clk),
    .reset     (rst),
    .producto  (producto),
    .valido    (valido),
    .ocupado   (ocupado),
    .AN        (AN),
    .SEG       (SEG),
    .DP        (DP)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int n);
    case (n)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // What a human would write on the display for value v, digit position d
  function automatic logic [6:0] model(input int v, input int d);
    int mag, nd, t, p, dig;
    mag = (v < 0) ? -v : v;
    nd = 1;
    t = mag / 10;
    while (t > 0) begin nd++; t = t / 10; end
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    dig = (mag / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (d < nd) return seg_of(dig);
    if (v < 0 && d == nd) return 7'b0111111;
    return 7'b1111111;
`else
    if (d < 5) return seg_of(dig);
    if (d == 5 && v < 0) return 7'b0111111;
    return 7'b1111111;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},  {24'd0, AN},  32'hFE);
    check({tag, "_seg"}, {25'd0, SEG}, 32'h40);
    check({tag, "_dp"},  {31'd0, DP},  32'd1);
    check({tag, "_ocu"}, {31'd0, ocupado}, 32'd0);
  endtask

  // Called at a negedge; pulses valido and counts busy cycles.
  task automatic convert(input logic [15:0] v, input int dup_at, input logic [15:0] dup_v);
    int busy;
    busy = 0;
    producto = v;
    valido = 1'b1;
    @(negedge clk);
    valido = 1'b0;
    producto = 16'($urandom);
    for (int c = 0; c < 40; c++) begin
      if (!ocupado) break;
      busy++;
      if (c == dup_at) begin producto = dup_v; valido = 1'b1; end
      else valido = 1'b0;
      @(negedge clk);
    end
    valido = 1'b0;
    check($sformatf("busy_%0h", v), busy, 32'd18);
  endtask

  task automatic check_display(input int v);
    logic [6:0] seen [8];
    int bad;
    int hit;
    bad = 0;
    for (int i = 0; i < 8; i++) seen[i] = 'x;
    repeat (RD + 1) @(negedge clk);
    for (int c = 0; c < 8 * RD; c++) begin
      hit = -1;
      for (int i = 0; i < 8; i++) if (AN == ~(8'd1 << i)) hit = i;
      if (hit < 0 || DP !== 1'b1) bad++;
      else seen[hit] = SEG;
      @(negedge clk);
    end
    check($sformatf("an_dp_v%0d", v), bad, 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("v%0d_d%0d", v, i), {25'd0, seen[i]}, {25'd0, model(v, i)});
  endtask

  task automatic run(input logic [15:0] p);
    convert(p, -1, 16'd0);
    check_display($signed(p));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;

    run(16'd12);
    run(16'hC080);
    run(16'h8000);
    run(16'h0000);

    convert(16'd7, 2, 16'd99);
    check_display(7);

    // reset in the middle of CONVERT
    producto = 16'd1234;
    valido = 1'b1;
    @(negedge clk);
    valido = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_mid_hold");
    rst = 1'b0;
    @(negedge clk);
    run(16'd5);

    // back-to-back acceptance at the earliest edge
    convert(16'd31415, -1, 16'd0);
    convert(16'hFFFF, -1, 16'd0);
    check_display(-1);

    for (int n = 0; n < 12; n++) run(16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
